// File: rtl/flag_ctrl_pkg.sv
// Shared opcode classes, condition codes and branch FSM states for the
// Z/V/N flag controller.
package flag_ctrl_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;

   localparam logic [2:0] CC_NE     = 3'b000;
   localparam logic [2:0] CC_EQ     = 3'b001;
   localparam logic [2:0] CC_GT     = 3'b010;
   localparam logic [2:0] CC_LT     = 3'b011;
   localparam logic [2:0] CC_GE     = 3'b100;
   localparam logic [2:0] CC_LE     = 3'b101;
   localparam logic [2:0] CC_OV     = 3'b110;
   localparam logic [2:0] CC_UNCOND = 3'b111;

   typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

   // Flags written by an opcode, packed as {Z, V, N}.
   function automatic logic [2:0] setter_mask(input logic [3:0] opcode);
      logic [2:0] m;
      case (opcode)
         OP_ADD, OP_SUB:                 m = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
         default:                        m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// Issue, writeback, flag-register and branch signals of the flag controller.
interface flag_branch_ctrl_if;

   logic       iss_valid;
   logic [3:0] iss_opcode;
   logic       iss_ready;

   logic       wb_valid;
   logic [3:0] wb_opcode;
   logic       alu_Z, alu_V, alu_N;

   logic       Z_en, V_en, N_en;
   logic       Z_in, V_in, N_in;
   logic       Z_out, V_out, N_out;

   logic       br_valid;
   logic [2:0] br_cond;
   logic       br_done;
   logic       br_taken;
   logic       br_stall;

   modport master (
      output iss_valid, iss_opcode, wb_valid, wb_opcode, alu_Z, alu_V, alu_N,
             Z_out, V_out, N_out, br_valid, br_cond,
      input  iss_ready, Z_en, V_en, N_en, Z_in, V_in, N_in,
             br_done, br_taken, br_stall
   );

   modport slave (
      input  iss_valid, iss_opcode, wb_valid, wb_opcode, alu_Z, alu_V, alu_N,
             Z_out, V_out, N_out, br_valid, br_cond,
      output iss_ready, Z_en, V_en, N_en, Z_in, V_in, N_in,
             br_done, br_taken, br_stall
   );

endinterface

// File: rtl/flag_cond_eval.sv
// Branch condition evaluation on the visible Z/V/N flags.
module flag_cond_eval
   import flag_ctrl_pkg::*;
(
   input  logic [2:0] i_cond,
   input  logic       i_z,
   input  logic       i_v,
   input  logic       i_n,
   output logic       o_taken
);

   always_comb begin
      o_taken = 1'b0;
      case (i_cond)
         CC_NE:     o_taken = !i_z;
         CC_EQ:     o_taken = i_z;
         CC_GT:     o_taken = !i_z & !i_n;
         CC_LT:     o_taken = i_n;
         CC_GE:     o_taken = i_z | !i_n;
         CC_LE:     o_taken = i_n | i_z;
         CC_OV:     o_taken = i_v;
         CC_UNCOND: o_taken = 1'b1;
         default:   o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Flag register write control, in-flight flag-producer scoreboard and
// conditional branch resolution with valid/done handshake.
module flag_branch_ctrl
   import flag_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input logic               clk,
   input logic               rst_n,
   flag_branch_ctrl_if.slave bus
);

   logic [2:0]       w_wb_mask;
   logic [2:0]       w_iss_mask;
   logic             w_inc;
   logic             w_dec;
   logic             w_iss_ready;
   logic             w_flags_ready;
   logic             w_taken;
   logic [CNT_W-1:0] r_cnt;
   state_t           r_state;
   logic             r_br_done;
   logic             r_br_taken;

   assign w_wb_mask  = setter_mask(bus.wb_opcode);
   assign w_iss_mask = setter_mask(bus.iss_opcode);

   assign w_dec       = bus.wb_valid & (|w_wb_mask);
   assign w_iss_ready = (r_cnt != '1) | w_dec;
   assign w_inc       = bus.iss_valid & w_iss_ready & (|w_iss_mask);
   // A retire of the last producer this cycle is seen through the flag bypass.
   assign w_flags_ready = (r_cnt == '0) | ((r_cnt == CNT_W'(1)) & w_dec);

   assign bus.iss_ready = w_iss_ready;

   assign {bus.Z_en, bus.V_en, bus.N_en} = {3{rst_n & bus.wb_valid}} & w_wb_mask;
   assign bus.Z_in = bus.alu_Z;
   assign bus.V_in = bus.alu_V;
   assign bus.N_in = bus.alu_N;

   flag_cond_eval u_cond_eval (
      .i_cond  (bus.br_cond),
      .i_z     (bus.Z_out),
      .i_v     (bus.V_out),
      .i_n     (bus.N_out),
      .o_taken (w_taken)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_inc & !w_dec) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dec & !w_inc & (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_br_done  <= 1'b0;
         r_br_taken <= 1'b0;
      end else begin
         r_br_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.br_valid) begin
                  if (w_flags_ready) begin
                     r_state    <= RESOLVE;
                     r_br_done  <= 1'b1;
                     r_br_taken <= w_taken;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (w_flags_ready) begin
                  r_state    <= RESOLVE;
                  r_br_done  <= 1'b1;
                  r_br_taken <= w_taken;
               end
            end
            RESOLVE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.br_done  = r_br_done;
   assign bus.br_taken = r_br_taken;
   assign bus.br_stall = (r_state == WAIT) |
                         ((r_state == IDLE) & bus.br_valid & !w_flags_ready);

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Directed bench for flag_branch_ctrl: per-cycle model comparison plus
// hand-computed spot checks.
module tb_flag_branch_ctrl;

   localparam int CNT_W  = 2;
   localparam int MAXCNT = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;

   flag_branch_ctrl_if bus ();

   flag_branch_ctrl #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Environment flag register with write-before-read.
   logic fr_z = 1'b0, fr_v = 1'b0, fr_n = 1'b0;
   assign bus.Z_out = bus.Z_en ? bus.Z_in : fr_z;
   assign bus.V_out = bus.V_en ? bus.V_in : fr_v;
   assign bus.N_out = bus.N_en ? bus.N_in : fr_n;
   always @(posedge clk) begin
      if (bus.Z_en) fr_z <= bus.Z_in;
      if (bus.V_en) fr_v <= bus.V_in;
      if (bus.N_en) fr_n <= bus.N_in;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit writes_all(input logic [3:0] op);
      return (op == 4'd0) || (op == 4'd1);
   endfunction

   function automatic bit writes_z(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
   endfunction

   function automatic bit cond_true(input logic [2:0] c, input bit z, input bit v, input bit n);
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   // Model: outstanding producer count, branch progress and flag contents.
   int m_cnt       = 0;
   bit m_known     = 0;
   bit m_waiting   = 0;
   bit m_resolving = 0;
   bit m_taken     = 0;
   bit m_z = 0, m_v = 0, m_n = 0;

   always @(negedge clk) begin
      bit dec, inc, rdy, frdy, ez, ev, en, fz, fv, fn, stall;
      dec   = bus.wb_valid && writes_z(bus.wb_opcode);
      rdy   = (m_cnt < MAXCNT) || dec;
      inc   = bus.iss_valid && rdy && writes_z(bus.iss_opcode);
      frdy  = (m_cnt == 0) || (m_cnt == 1 && dec);
      ez    = rst_n && bus.wb_valid && writes_z(bus.wb_opcode);
      ev    = rst_n && bus.wb_valid && writes_all(bus.wb_opcode);
      en    = ev;
      fz    = ez ? bus.alu_Z : m_z;
      fv    = ev ? bus.alu_V : m_v;
      fn    = en ? bus.alu_N : m_n;
      stall = m_waiting || (!m_resolving && bus.br_valid && !frdy);
      if (m_known) begin
         chk("m_iss_ready", bus.iss_ready, rdy);
         chk("m_Z_en", bus.Z_en, ez);
         chk("m_V_en", bus.V_en, ev);
         chk("m_N_en", bus.N_en, en);
         chk("m_Z_in", bus.Z_in, bus.alu_Z);
         chk("m_V_in", bus.V_in, bus.alu_V);
         chk("m_N_in", bus.N_in, bus.alu_N);
         chk("m_br_done", bus.br_done, m_resolving);
         chk("m_br_taken", bus.br_taken, m_taken);
         chk("m_br_stall", bus.br_stall, stall);
      end
      if (!rst_n) begin
         m_cnt = 0; m_waiting = 0; m_resolving = 0; m_taken = 0; m_known = 1;
      end else begin
         m_cnt = m_cnt + int'(inc) - int'(dec);
         if (m_cnt < 0) m_cnt = 0;
         if (m_resolving) begin
            m_resolving = 0;
         end else if (m_waiting || bus.br_valid) begin
            if (frdy) begin
               m_resolving = 1;
               m_waiting   = 0;
               m_taken     = cond_true(bus.br_cond, fz, fv, fn);
            end else begin
               m_waiting = 1;
            end
         end
      end
      if (ez) m_z = bus.alu_Z;
      if (ev) m_v = bus.alu_V;
      if (en) m_n = bus.alu_N;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wb(input logic vld, input logic [3:0] op, input logic z, input logic v, input logic n);
      bus.wb_valid  = vld;
      bus.wb_opcode = op;
      bus.alu_Z = z;
      bus.alu_V = v;
      bus.alu_N = n;
   endtask

   logic [7:0] exp_tbl [2];

   initial begin
      rst_n = 1'b0;
      bus.iss_valid = 1'b0; bus.iss_opcode = 4'd0;
      set_wb(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      bus.br_valid = 1'b0; bus.br_cond = 3'd0;
      tick(); tick();
      rst_n = 1'b1;
      #2;
      chk("rst_iss_ready", bus.iss_ready, 1'b1);
      chk("rst_br_done", bus.br_done, 1'b0);
      chk("rst_br_taken", bus.br_taken, 1'b0);
      chk("rst_br_stall", bus.br_stall, 1'b0);

      tick();
      set_wb(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
      #2;
      chk("add_Z_en", bus.Z_en, 1'b1);
      chk("add_V_en", bus.V_en, 1'b1);
      chk("add_N_en", bus.N_en, 1'b1);
      chk("add_Z_in", bus.Z_in, 1'b1);
      chk("add_N_in", bus.N_in, 1'b1);

      tick();
      set_wb(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1);
      #2;
      chk("xor_Z_en", bus.Z_en, 1'b1);
      chk("xor_V_en", bus.V_en, 1'b0);
      chk("xor_N_en", bus.N_en, 1'b0);

      // Counter saturated at 0: LT on N=1 resolves without stalling.
      tick();
      bus.wb_valid = 1'b0;
      bus.br_valid = 1'b1; bus.br_cond = 3'b011;
      #2 chk("sat_no_stall", bus.br_stall, 1'b0);
      tick();
      #2;
      chk("sat_done", bus.br_done, 1'b1);
      chk("sat_taken", bus.br_taken, 1'b1);
      tick();
      bus.br_valid = 1'b0;
      tick();

      // Issue SUB, branch EQ two cycles later, retire SUB one cycle after that.
      bus.iss_valid = 1'b1; bus.iss_opcode = 4'b0001;
      tick();
      bus.iss_valid = 1'b0;
      tick();
      bus.br_valid = 1'b1; bus.br_cond = 3'b001;
      #2 chk("eq_stall_idle", bus.br_stall, 1'b1);
      tick();
      set_wb(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
      #2 chk("eq_stall_wb", bus.br_stall, 1'b1);
      tick();
      bus.wb_valid = 1'b0;
      #2;
      chk("eq_done", bus.br_done, 1'b1);
      chk("eq_taken", bus.br_taken, 1'b1);
      chk("eq_stall_off", bus.br_stall, 1'b0);
      tick();
      bus.br_valid = 1'b0;
      #2;
      chk("eq_done_pulse", bus.br_done, 1'b0);
      chk("eq_taken_hold", bus.br_taken, 1'b1);

      // Scoreboard: inc+dec at 1, then fill to max.
      tick();
      bus.iss_valid = 1'b1; bus.iss_opcode = 4'b0000;
      tick();
      set_wb(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      #2 chk("incdec_ready", bus.iss_ready, 1'b1);
      tick();
      bus.wb_valid = 1'b0;
      tick();
      tick();
      #2 chk("full_ready", bus.iss_ready, 1'b0);
      tick();
      #2 chk("full_ready_hold", bus.iss_ready, 1'b0);
      set_wb(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      #1 chk("full_dec_ready", bus.iss_ready, 1'b1);
      tick();
      bus.iss_valid = 1'b0;
      tick(); tick(); tick();
      bus.wb_valid = 1'b0;
      #2 chk("drained_ready", bus.iss_ready, 1'b1);
      tick();

      // All eight conditions, for flags Z0V0N0 then Z0V1N1.
      exp_tbl[0] = 8'b1001_0101;
      exp_tbl[1] = 8'b1110_1001;
      for (int p = 0; p < 2; p++) begin
         if (p == 1) begin
            set_wb(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
            tick();
            bus.wb_valid = 1'b0;
         end
         for (int c = 0; c < 8; c++) begin
            bus.br_valid = 1'b1; bus.br_cond = 3'(c);
            #2 chk($sformatf("p%0d_cc%0d_stall", p, c), bus.br_stall, 1'b0);
            tick();
            #2;
            chk($sformatf("p%0d_cc%0d_done", p, c), bus.br_done, 1'b1);
            chk($sformatf("p%0d_cc%0d_taken", p, c), bus.br_taken, exp_tbl[p][c]);
            tick();
            bus.br_valid = 1'b0;
            tick();
         end
      end

      // Last producer retires in the branch's first cycle: no stall.
      bus.iss_valid = 1'b1; bus.iss_opcode = 4'b0001;
      tick();
      bus.iss_valid = 1'b0;
      bus.br_valid = 1'b1; bus.br_cond = 3'b001;
      set_wb(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
      #2 chk("byp_stall", bus.br_stall, 1'b0);
      tick();
      bus.wb_valid = 1'b0;
      #2;
      chk("byp_done", bus.br_done, 1'b1);
      chk("byp_taken", bus.br_taken, 1'b1);
      tick();
      bus.br_valid = 1'b0;
      tick();

      // Reset while waiting drops the branch.
      bus.iss_valid = 1'b1; bus.iss_opcode = 4'b0000;
      tick();
      bus.iss_valid = 1'b0;
      bus.br_valid = 1'b1; bus.br_cond = 3'b111;
      tick();
      rst_n = 1'b0;
      #2 chk("rstw_stall_before", bus.br_stall, 1'b1);
      tick();
      rst_n = 1'b1;
      bus.br_valid = 1'b0;
      #2;
      chk("rstw_stall", bus.br_stall, 1'b0);
      chk("rstw_done", bus.br_done, 1'b0);
      chk("rstw_taken", bus.br_taken, 1'b0);
      chk("rstw_ready", bus.iss_ready, 1'b1);
      tick();
      bus.br_valid = 1'b1; bus.br_cond = 3'b111;
      #2 chk("rstw_cnt0_stall", bus.br_stall, 1'b0);
      tick();
      #2;
      chk("rstw_redo_done", bus.br_done, 1'b1);
      chk("rstw_redo_taken", bus.br_taken, 1'b1);
      tick();
      bus.br_valid = 1'b0;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
